serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition, sampled on clk rising edge.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, sampled only when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress (states LOAD-accepted through DONE).
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking sum/cout valid.
REQ-010 The block SHALL have port sum  output  WIDTH  result a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL be accepted: a, b, cin latched into operand shift registers and carry flop, bit counter cleared to 0, sum register cleared to 0, state to SHIFT.
REQ-014 start SHALL be ignored in SHIFT and DONE; a, b, cin changes outside acceptance SHALL have no effect.
REQ-015 Each SHIFT edge SHALL process one bit LSB-first: s = a0 ^ b0 ^ c, c_next = (a0 & b0) | (c & (a0 ^ b0)).
REQ-016 The one-bit full adder SHALL be built from the team's base gate library only: two xor_mod, two and_mod, one or_mod instances.
REQ-017 Per SHIFT edge: operand registers SHALL shift right by one, s SHALL enter sum register MSB with sum shifted right, carry flop SHALL load c_next, counter SHALL increment.
REQ-018 At the SHIFT edge where counter equals WIDTH-1, state SHALL go to DONE; sum and cout SHALL hold the final result from that edge.
REQ-019 done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge 0 -> result registered at edge WIDTH, done high between edges WIDTH and WIDTH+1; minimum start-to-start spacing WIDTH+2 edges.
REQ-021 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-022 sum and cout SHALL hold the last completed result in IDLE until the next start is accepted (then sum clears per REQ-013; cout SHALL hold until first SHIFT edge updates it).
REQ-023 cout output SHALL be the carry flop; counter width SHALL be clog2(WIDTH)+1 bits, no wrap within an operation.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, operand registers=0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; after rst_n rises, the first accepted start SHALL produce a correct result.
REQ-026 start high on the first edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=0xFF, b=0x01, cin=0, start at edge 0 -> done high after edge 8, sum=0x00, cout=1, busy 0 after edge 9.
REQ-028 WIDTH=8, a=0x5A, b=0x33, cin=1 -> sum=0x8E, cout=0, done exactly one cycle.
REQ-029 start=1 held continuously with changing a/b during SHIFT -> first operands' result only; second start accepted at edge 10 (first IDLE edge).
REQ-030 rst_n pulsed low at edge 4 of an operation -> done never pulses, sum=0, cout=0 immediately; subsequent 0x10+0x20+0 -> sum=0x30, cout=0.
REQ-031 WIDTH=4, a=0xF, b=0xF, cin=1 -> done after edge 4, sum=0xF, cout=1.
REQ-032 Random 1000 operations, WIDTH=8 -> {cout,sum} equals a+b+cin each time; done count equals accepted-start count.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice built from base gates, iterated
// LSB-first over WIDTH clock edges with a three-state controller.

module xor_mod (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module and_mod (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_mod (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic             cin_reg;
   logic             busy_reg;
   logic             done_reg;

   logic c_in;
   logic x_ab;
   logic s_bit;
   logic gen;
   logic prop;
   logic c_next;

   // The accepted carry-in is applied on the first shift so the carry flop
   // (and therefore cout) keeps the previous result until that edge.
   assign c_in = (cnt_reg == '0) ? cin_reg : carry_reg;

   xor_mod u_xor_ab (.a(a_reg[0]), .b(b_reg[0]), .y(x_ab));
   xor_mod u_xor_s  (.a(x_ab),     .b(c_in),     .y(s_bit));
   and_mod u_and_g  (.a(a_reg[0]), .b(b_reg[0]), .y(gen));
   and_mod u_and_p  (.a(c_in),     .b(x_ab),     .y(prop));
   or_mod  u_or_c   (.a(gen),      .b(prop),     .y(c_next));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cin_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  cin_reg   <= cin;
                  cnt_reg   <= '0;
                  sum_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               a_reg     <= a_reg >> 1;
               b_reg     <= b_reg >> 1;
               sum_reg   <= {s_bit, sum_reg[WIDTH-1:1]};
               carry_reg <= c_next;
               cnt_reg   <= cnt_reg + CW'(1);
               if (cnt_reg == LAST) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign sum  = sum_reg;
   assign cout = carry_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {cout,sum} queued at launch,
// popped and compared when done is observed.

module tb_serial_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   int checks   = 0;
   int failures = 0;
   int accepts8 = 0;
   int aborted8 = 0;
   int dones8   = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   always @(negedge clk) if (done8 === 1'b1) dones8++;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
      start8 = 1'b1;
      a8     = a;
      b8     = b;
      cin8   = c;
      q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
      accepts8++;
   endtask

   // Waits for done (bounded), checks latency and result, then the idle cycle.
   task automatic finish8(input int exp_k);
      int         k;
      logic [8:0] exp;
      k = 0;
      while (1) begin
         @(negedge clk);
         start8 = 1'b0;
         k++;
         if (done8 === 1'b1 || k >= 3 * 8) break;
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         cin8 = 1'($urandom);
      end
      check_val("latency8", 64'(k), 64'(exp_k));
      if (q8.size() == 0) begin
         check_val("q8_empty", 64'(1), 64'(0));
         return;
      end
      exp = q8.pop_front();
      check_val("sum8", 64'(sum8), 64'(exp[7:0]));
      check_val("cout8", 64'(cout8), 64'(exp[8]));
      $display("op8 sum=%02h cout=%0d exp_sum=%02h exp_cout=%0d", sum8, cout8, exp[7:0], exp[8]);
      @(negedge clk);
      check_val("done8_pulse", 64'(done8), 64'(0));
      check_val("busy8_idle", 64'(busy8), 64'(0));
      check_val("sum8_hold", 64'(sum8), 64'(exp[7:0]));
      check_val("cout8_hold", 64'(cout8), 64'(exp[8]));
   endtask

   initial begin
      logic [8:0] exp;
      logic [4:0] exp4;
      int         d0;
      int         k;

      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      #2;
      check_val("rst_busy8", 64'(busy8), 64'(0));
      check_val("rst_done8", 64'(done8), 64'(0));
      check_val("rst_sum8", 64'(sum8), 64'(0));
      check_val("rst_cout8", 64'(cout8), 64'(0));
      check_val("rst_sum4", 64'(sum4), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Carry ripples through all bits; start on the first edge after reset release
      launch8(8'hFF, 8'h01, 1'b0);
      finish8(9);

      // Sum clears on accept while cout keeps the previous carry
      launch8(8'h5A, 8'h33, 1'b1);
      @(negedge clk);
      start8 = 1'b0;
      check_val("sum8_clear", 64'(sum8), 64'(0));
      check_val("cout8_keep", 64'(cout8), 64'(1));
      check_val("busy8_run", 64'(busy8), 64'(1));
      finish8(8);

      // start held high with operands churning during the operation
      launch8(8'hC3, 8'h4E, 1'b0);
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 9) check_val("held_nodone", 64'(done8), 64'(0));
         if (k == 9) begin
            check_val("held_done", 64'(done8), 64'(1));
            exp = q8.pop_front();
            check_val("held_sum", 64'(sum8), 64'(exp[7:0]));
            check_val("held_cout", 64'(cout8), 64'(exp[8]));
            $display("op8 held sum=%02h cout=%0d exp_sum=%02h exp_cout=%0d", sum8, cout8, exp[7:0], exp[8]);
         end
         if (k == 10) begin
            check_val("held_idle_busy", 64'(busy8), 64'(0));
            launch8(8'h21, 8'h9D, 1'b1);
         end else begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
         end
      end
      @(negedge clk);
      check_val("held_accept", 64'(busy8), 64'(1));
      finish8(8);

      // Abort mid-operation with reset
      launch8(8'hAA, 8'h77, 1'b1);
      for (k = 0; k < 4; k++) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("abort_sum", 64'(sum8), 64'(0));
      check_val("abort_cout", 64'(cout8), 64'(0));
      check_val("abort_busy", 64'(busy8), 64'(0));
      q8.delete();
      aborted8++;
      for (k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("abort_nodone", 64'(done8), 64'(0));
      end
      rst_n = 1'b1;
      launch8(8'h10, 8'h20, 1'b0);
      finish8(9);

      // Narrow instance
      @(negedge clk);
      start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
      q4.push_back({1'b0, a4} + {1'b0, b4} + 5'(cin4));
      k = 0;
      while (1) begin
         @(negedge clk);
         start4 = 1'b0;
         k++;
         if (done4 === 1'b1 || k >= 12) break;
      end
      exp4 = q4.pop_front();
      check_val("latency4", 64'(k), 64'(5));
      check_val("sum4", 64'(sum4), 64'(exp4[3:0]));
      check_val("cout4", 64'(cout4), 64'(exp4[4]));
      $display("op4 sum=%01h cout=%0d exp_sum=%01h exp_cout=%0d", sum4, cout4, exp4[3:0], exp4[4]);
      @(negedge clk);
      check_val("done4_pulse", 64'(done4), 64'(0));

      // Random back-to-back operations
      d0 = dones8;
      repeat (1000) begin
         launch8(8'($urandom), 8'($urandom), 1'($urandom));
         finish8(9);
      end
      check_val("rand_done_count", 64'(dones8 - d0), 64'(1000));
      check_val("total_done_count", 64'(dones8), 64'(accepts8 - aborted8));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
